// File: rtl/fbindct_bram_arbiter.sv
// rtl/fbindct_bram_arbiter.sv - Read/write arbiter sharing one BRAM port with bounded round-robin bursts.
// Grants are combinational from requests and burst state; read data returns with a fixed latency.
module fbindct_bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int BURST_MAX  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wrdata,
  input  logic [DATA_WIDTH-1:0] bram_rddata,
  output logic                  bram_en,
  output logic                  bram_we
);

  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_RD, OWN_WR} owner_t;

  owner_t                owner_q, owner_d;
  logic [CW-1:0]         beat_q, beat_d;
  logic                  last_wr_q, last_wr_d;
  logic [RD_LATENCY-1:0] vpipe_q;
  logic                  rd_gnt_c, wr_gnt_c;
  logic                  burst_done;
  logic [CW-1:0]         beat_inc;

  assign burst_done = (beat_q >= CW'(BURST_MAX));
  assign beat_inc   = burst_done ? beat_q : beat_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      beat_q    <= '0;
      last_wr_q <= 1'b1;
    end else begin
      owner_q   <= owner_d;
      beat_q    <= beat_d;
      last_wr_q <= last_wr_d;
    end
  end

  always_comb begin
    rd_gnt_c  = 1'b0;
    wr_gnt_c  = 1'b0;
    owner_d   = OWN_NONE;
    beat_d    = '0;
    last_wr_d = last_wr_q;
    if (!rst) begin
      if (rd_req && !wr_req) begin
        rd_gnt_c = 1'b1;
      end else if (wr_req && !rd_req) begin
        wr_gnt_c = 1'b1;
      end else if (rd_req && wr_req) begin
        // Contention: the current owner keeps the port until its burst is used up.
        case (owner_q)
          OWN_RD: begin
            if (burst_done) wr_gnt_c = 1'b1;
            else            rd_gnt_c = 1'b1;
          end
          OWN_WR: begin
            if (burst_done) rd_gnt_c = 1'b1;
            else            wr_gnt_c = 1'b1;
          end
          default: begin
            if (last_wr_q) rd_gnt_c = 1'b1;
            else           wr_gnt_c = 1'b1;
          end
        endcase
      end
    end
    if (rd_gnt_c) begin
      owner_d   = OWN_RD;
      last_wr_d = 1'b0;
      beat_d    = (owner_q == OWN_RD) ? beat_inc : CW'(1);
    end else if (wr_gnt_c) begin
      owner_d   = OWN_WR;
      last_wr_d = 1'b1;
      beat_d    = (owner_q == OWN_WR) ? beat_inc : CW'(1);
    end
  end

  // Valid pipe is cleared on reset so in-flight reads never return.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q[0] <= rd_gnt_c;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
      end
    end
  end

  assign rd_gnt      = rd_gnt_c;
  assign wr_gnt      = wr_gnt_c;
  assign rd_valid    = vpipe_q[RD_LATENCY-1] & ~rst;
  assign rd_data     = bram_rddata;
  assign bram_en     = rd_gnt_c | wr_gnt_c;
  assign bram_we     = wr_gnt_c;
  assign bram_addr   = wr_gnt_c ? wr_addr : (rd_gnt_c ? rd_addr : '0);
  assign bram_wrdata = wr_gnt_c ? wr_data : '0;

endmodule
